// File: rtl/ct_spsram_ctrl_pkg.sv
// ct_spsram_ctrl_pkg: shared widths, depth and controller state type
package ct_spsram_ctrl_pkg;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 144;
    localparam int DEPTH          = 256;
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// ct_spsram_rsp_fifo: 2-entry in-order read response buffer
module ct_spsram_rsp_fifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  vld,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  pop_ok;

    assign vld    = cnt != 2'd0;
    assign pop_ok = pop & vld;
    assign rdata  = mem[rd_ptr];

    // storage and pointers; a simultaneous push and pop leaves cnt unchanged
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop_ok};
        end
    end
endmodule

// File: rtl/ct_spsram_256x144_ctrl.sv
// ct_spsram_256x144_ctrl: request/response front end for a 1-cycle-latency single-port SRAM
// Optional zero-fill sweep after reset is built when CT_SPSRAM_INIT_EN is defined.
module ct_spsram_256x144_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    state_e                state;
    state_e                state_nxt;
    logic                  run;
    logic                  sweep;
    logic                  sweep_last;
    logic [ADDR_WIDTH-1:0] sweep_a;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_pend;
    logic                  rsp_pop;
    logic [1:0]            fifo_cnt;
    logic [1:0]            occ;
    logic [ADDR_WIDTH-1:0] a_q;

    assign run     = state == ST_RUN;
    assign rsp_pop = rsp_vld & rsp_rdy;

`ifdef CT_SPSRAM_INIT_EN
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    // zero-fill address walks one entry per cycle while in INIT
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            sweep_cnt <= '0;
        else if (state == ST_INIT)
            sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
    end

    // reset gating keeps the SRAM idle while cpurst_b is low
    assign sweep      = (state == ST_INIT) & cpurst_b;
    assign sweep_a    = sweep_cnt;
    assign sweep_last = sweep_cnt == ADDR_WIDTH'(DEPTH - 1);
    assign init_done  = run;
`else
    assign sweep      = 1'b0;
    assign sweep_a    = '0;
    assign sweep_last = 1'b1;
    assign init_done  = 1'b1;
`endif

    // state register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    // leave INIT once the sweep has covered the last address
    always_comb begin
        state_nxt = (state == ST_INIT && sweep_last) ? ST_RUN : state;
    end

    // handshake and SRAM pins; reads limited so the 2-entry FIFO never overflows
    always_comb begin
        occ       = {1'b0, rd_pend} + fifo_cnt - {1'b0, rsp_pop};
        req_rdy   = run & (req_wr | (occ < 2'd2));
        wr_acc    = req_vld & req_rdy & req_wr;
        rd_acc    = req_vld & req_rdy & ~req_wr;
        sram_cen  = ~(sweep | (wr_acc & |req_wmask) | rd_acc);
        sram_gwen = ~(sweep | wr_acc);
        sram_a    = sweep ? sweep_a : (wr_acc | rd_acc) ? req_addr : a_q;
        sram_d    = wr_acc ? req_wdata : '0;
        sram_wen  = sweep ? '0 : wr_acc ? ~req_wmask : '1;
    end

    // last driven address is held while idle; read issued last cycle returns data now
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            a_q     <= '0;
            rd_pend <= 1'b0;
        end else begin
            a_q     <= sram_a;
            rd_pend <= rd_acc;
        end
    end

    ct_spsram_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_fifo (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .push           (rd_pend),
        .push_data      (sram_q),
        .pop            (rsp_pop),
        .vld            (rsp_vld),
        .cnt            (fifo_cnt),
        .rdata          (rsp_rdata)
    );
endmodule

// File: tb/tb_ct_spsram_256x144_ctrl.sv
// tb_ct_spsram_256x144_ctrl: SRAM model plus transaction-level reference for the controller
module tb_ct_spsram_256x144_ctrl;
    localparam int AW = 8;
    localparam int DW = 144;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b       = 1'b1;
    logic          req_vld        = 1'b0;
    logic          req_rdy;
    logic          req_wr         = 1'b0;
    logic [AW-1:0] req_addr       = '0;
    logic [DW-1:0] req_wdata      = '0;
    logic [DW-1:0] req_wmask      = '0;
    logic          rsp_vld;
    logic          rsp_rdy        = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_q         = '0;

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_spsram_256x144_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_d         (sram_d),
        .sram_wen       (sram_wen),
        .sram_q         (sram_q)
    );

    // single-port SRAM, active-low enables, per-bit write enable, 1-cycle read
    logic [DW-1:0] sram_mem [256];
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
        logic [DW-1:0] exp;
    } vec_t;

    logic [DW-1:0] ref_mem [256];
    rsp_t          exp_q [$];
    int            cyc;
    int            tests;
    int            fails;
    logic          held;
    logic [DW-1:0] held_data;
    logic [DW-1:0] pop_data;
    logic [AW-1:0] last_a;

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // assert reset for two cycles, check reset outputs, release at a falling edge
    task automatic apply_reset();
        req_vld  = 1'b0;
        req_wr   = 1'b0;
        rsp_rdy  = 1'b0;
        cpurst_b = 1'b0;
        #1;
        chk1("rst_rsp_vld", rsp_vld, 1'b0);
        chkd("rst_rsp_rdata", rsp_rdata, '0);
        chk1("rst_cen", sram_cen, 1'b1);
        chk1("rst_gwen", sram_gwen, 1'b1);
        chkd("rst_wen", sram_wen, '1);
        chkd("rst_d", sram_d, '0);
        chk8("rst_a", sram_a, '0);
        chk1("rst_req_rdy", req_rdy, 1'b0);
`ifdef CT_SPSRAM_INIT_EN
        chk1("rst_init_done", init_done, 1'b0);
`else
        chk1("rst_init_done", init_done, 1'b1);
`endif
        repeat (2) @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        exp_q.delete();
        held = 1'b0;
    endtask

    // follow the post-reset INIT phase for n cycles
    task automatic init_seq(input int n);
`ifdef CT_SPSRAM_INIT_EN
        int bad;
        for (int i = 0; i < n; i++) begin
            req_vld = 1'b0;
            req_wr  = 1'b1;
            #1;
            chk1("sweep_init_done", init_done, 1'b0);
            chk1("sweep_req_rdy", req_rdy, 1'b0);
            chk8("sweep_addr", sram_a, AW'(i));
            chk1("sweep_cen", sram_cen, 1'b0);
            chk1("sweep_gwen", sram_gwen, 1'b0);
            chkd("sweep_wen", sram_wen, '0);
            chkd("sweep_d", sram_d, '0);
            @(negedge forever_cpuclk);
        end
        if (n == 256) begin
            #1;
            chk1("init_done_up", init_done, 1'b1);
            chk1("init_req_rdy", req_rdy, 1'b1);
            bad = 0;
            for (int j = 0; j < 256; j++)
                if (sram_mem[j] !== '0)
                    bad++;
            chkd("sweep_zeroed", DW'(bad), '0);
            for (int j = 0; j < 256; j++)
                ref_mem[j] = '0;
            last_a = 8'hFF;
        end
`else
        req_vld = 1'b0;
        req_wr  = 1'b1;
        #1;
        chk1("init_done_const", init_done, 1'b1);
        chk1("init_req_rdy_low", req_rdy, 1'b0);
        @(negedge forever_cpuclk);
        #1;
        chk1("run_req_rdy", req_rdy, 1'b1);
        last_a = '0;
`endif
    endtask

    // one RUN cycle: drive at the falling edge, check against the reference, advance
    task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m, input logic rr,
                         output logic acc, output logic pop);
        logic exp_vld;
        logic exp_pop;
        logic exp_rdy;
        req_vld   = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        rsp_rdy   = rr;
        #1;
        exp_vld = exp_q.size() > 0 && cyc >= exp_q[0].cyc + 2;
        chk1("rsp_vld", rsp_vld, exp_vld);
        exp_pop = exp_vld && rr;
        exp_rdy = w || ((exp_q.size() - (exp_pop ? 1 : 0)) < 2);
        chk1("req_rdy", req_rdy, exp_rdy);
        if (held)
            chkd("rsp_hold", rsp_rdata, held_data);
        if (exp_pop) begin
            chkd("rsp_rdata", rsp_rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        held      = rsp_vld && !rr;
        held_data = rsp_rdata;
        pop       = rsp_vld && rr;
        if (pop)
            pop_data = rsp_rdata;
        acc = v && req_rdy;
        if (acc && w) begin
            if (m == '0) begin
                chk1("zmask_cen", sram_cen, 1'b1);
            end else begin
                chk1("wr_cen", sram_cen, 1'b0);
                chk1("wr_gwen", sram_gwen, 1'b0);
                chk8("wr_a", sram_a, a);
                chkd("wr_d", sram_d, d);
                chkd("wr_wen", sram_wen, ~m);
            end
            ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            last_a = a;
        end else if (acc) begin
            chk1("rd_cen", sram_cen, 1'b0);
            chk1("rd_gwen", sram_gwen, 1'b1);
            chkd("rd_wen", sram_wen, '1);
            chk8("rd_a", sram_a, a);
            exp_q.push_back('{data: ref_mem[a], cyc: cyc});
            last_a = a;
        end else begin
            chk1("idle_cen", sram_cen, 1'b1);
            chk1("idle_gwen", sram_gwen, 1'b1);
            chkd("idle_wen", sram_wen, '1);
            chkd("idle_d", sram_d, '0);
            chk8("idle_a", sram_a, last_a);
        end
        cyc++;
        @(negedge forever_cpuclk);
    endtask

    task automatic idle(input logic rr, output logic pop);
        logic acc;
        cycle(1'b0, 1'b0, '0, '0, '0, rr, acc, pop);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          tbl [8];
        logic          acc;
        logic          pop;
        logic [DW-1:0] got [8];
        int            at [8];
        int            n;
        int            c0;
        int            t;

        tbl[0] = '{1'b1, 8'h12, '1, 144'hFF, '0};
        tbl[1] = '{1'b0, 8'h12, '0, '0, 144'hFF};
        tbl[2] = '{1'b1, 8'h34, {18{8'hA5}}, '1, '0};
        tbl[3] = '{1'b1, 8'h34, '0, {72'h0, {72{1'b1}}}, '0};
        tbl[4] = '{1'b0, 8'h34, '0, '0, {{9{8'hA5}}, 72'h0}};
        tbl[5] = '{1'b1, 8'h12, '1, '0, '0};
        tbl[6] = '{1'b0, 8'h12, '0, '0, 144'hFF};
        tbl[7] = '{1'b0, 8'h00, '0, '0, '0};

        for (int i = 0; i < 256; i++) begin
`ifdef CT_SPSRAM_INIT_EN
            sram_mem[i] = rnd() | 144'h1;
`else
            sram_mem[i] = '0;
`endif
            ref_mem[i] = '0;
        end
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        held     = 1'b0;
        pop_data = '0;
        last_a   = '0;

`ifdef CT_SPSRAM_INIT_EN
        // reset pulsed while the sweep is at address 100 restarts it from 0
        apply_reset();
        init_seq(100);
`endif
        apply_reset();
        init_seq(256);

        // directed vectors: masked writes, zero-mask write, read-back
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].wmask, 1'b1, acc, pop);
            chk1("tbl_acc", acc, 1'b1);
            if (!tbl[k].wr) begin
                idle(1'b1, pop);
                chk1("tbl_lat1", pop, 1'b0);
                idle(1'b1, pop);
                chk1("tbl_lat2", pop, 1'b1);
                chkd("tbl_rdata", pop_data, tbl[k].exp);
            end
        end

        // back-to-back reads of 1..4 with the response side always ready
        for (int k = 1; k <= 4; k++)
            cycle(1'b1, 1'b1, AW'(k), {18{8'(k)}}, '1, 1'b1, acc, pop);
        c0 = cyc;
        n  = 0;
        for (int k = 0; k < 8; k++) begin
            t = cyc;
            cycle(k < 4, 1'b0, AW'(k + 1), '0, '0, 1'b1, acc, pop);
            if (k < 4)
                chk1("b2b_acc", acc, 1'b1);
            if (pop) begin
                got[n] = pop_data;
                at[n]  = t;
                n++;
            end
        end
        chk8("b2b_count", AW'(n), 8'd4);
        for (int j = 0; j < 4 && j < n; j++) begin
            chk8("b2b_cycle", AW'(at[j] - c0), AW'(j + 2));
            chkd("b2b_data", got[j], {18{8'(j + 1)}});
        end

        // back-pressure: two reads outstanding, third refused, write still flows
        cycle(1'b1, 1'b1, 8'h05, {18{8'h11}}, '1, 1'b1, acc, pop);
        cycle(1'b1, 1'b1, 8'h06, {18{8'h22}}, '1, 1'b1, acc, pop);
        cycle(1'b1, 1'b0, 8'h05, '0, '0, 1'b0, acc, pop);
        chk1("bp_acc0", acc, 1'b1);
        cycle(1'b1, 1'b0, 8'h06, '0, '0, 1'b0, acc, pop);
        chk1("bp_acc1", acc, 1'b1);
        cycle(1'b1, 1'b0, 8'h07, '0, '0, 1'b0, acc, pop);
        chk1("bp_refused", acc, 1'b0);
        cycle(1'b1, 1'b1, 8'h05, {18{8'h33}}, '1, 1'b0, acc, pop);
        chk1("bp_write", acc, 1'b1);
        repeat (3) idle(1'b0, pop);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            idle(1'b1, pop);
            if (pop) begin
                got[n] = pop_data;
                n++;
            end
        end
        chk8("bp_count", AW'(n), 8'd2);
        chkd("bp_old_data", got[0], {18{8'h11}});
        chkd("bp_second", got[1], {18{8'h22}});
        cycle(1'b1, 1'b0, 8'h05, '0, '0, 1'b1, acc, pop);
        idle(1'b1, pop);
        idle(1'b1, pop);
        chkd("bp_new_data", pop_data, {18{8'h33}});

        // randomised traffic on a small address window against the reference
        for (int k = 0; k < 500; k++) begin
            logic [DW-1:0] m;
            int            sel;
            sel = $urandom_range(0, 3);
            m   = (sel == 0) ? '0 : (sel == 1) ? '1 : rnd();
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  rnd(), m, $urandom_range(0, 3) != 0, acc, pop);
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            idle(1'b1, pop);
        chk8("drain_left", AW'(exp_q.size()), 8'd0);

        // reset while reads are in flight discards them
        cycle(1'b1, 1'b0, 8'h03, '0, '0, 1'b1, acc, pop);
        cycle(1'b1, 1'b0, 8'h04, '0, '0, 1'b1, acc, pop);
        apply_reset();
        init_seq(256);
        repeat (4) idle(1'b1, pop);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ct_spsram_256x144_ctrl.md
CT_SPSRAM_256X144_CTRL -- requirements
Module: ct_spsram_256x144_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: SRAM address width (256 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 144: SRAM word width.
REQ-003 SHALL have port forever_cpuclk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port cpurst_b, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports req_vld (input, 1) and req_rdy (output, 1): request handshake.
REQ-006 SHALL have port req_wr, input, 1: request type, 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, ADDR_WIDTH: request address.
REQ-008 SHALL have ports req_wdata (input, DATA_WIDTH) and req_wmask (input, DATA_WIDTH): write data and per-bit enable, 1 = write.
REQ-009 SHALL have ports rsp_vld (output, 1), rsp_rdy (input, 1) and rsp_rdata (output, DATA_WIDTH): read response.
REQ-010 SHALL have port init_done, output, 1: array ready for traffic.
REQ-011 SHALL have SRAM-side ports sram_a (output, ADDR_WIDTH), sram_cen (output, 1), sram_gwen (output, 1), sram_d (output, DATA_WIDTH), sram_wen (output, DATA_WIDTH) and sram_q (input, DATA_WIDTH); all enables are active-low; the read latency is 1 cycle.

Function
REQ-012 SHALL run FSM states INIT and RUN; reset enters INIT, and INIT->RUN follows sweep completion.
REQ-013 SHALL hold req_rdy low in INIT.
REQ-014 In RUN, SHALL hold req_rdy high for writes; for reads, SHALL raise req_rdy only when (inflight reads + buffered responses - response popped this cycle) < 2.
REQ-015 On an accepted write (req_vld & req_rdy & req_wr), SHALL drive in the same cycle: sram_cen=0, sram_gwen=0, sram_a=req_addr, sram_d=req_wdata, sram_wen=~req_wmask.
REQ-016 On an accepted write with req_wmask all-zero, SHALL keep sram_cen=1 (no SRAM access) while the request is still consumed.
REQ-017 On an accepted read, SHALL drive sram_cen=0, sram_gwen=1, sram_wen=all-ones and sram_a=req_addr.
REQ-018 SHALL capture sram_q in the following cycle into a 2-entry in-order response FIFO, giving rsp_vld 2 cycles after acceptance.
REQ-019 With no accepted request, SHALL drive sram_cen=1, sram_gwen=1, sram_wen=all-ones, sram_d=0, and hold sram_a at its last value.
REQ-020 SHALL pop a response on rsp_vld & rsp_rdy; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-021 SHALL hold rsp_rdata stable while rsp_vld=1 and rsp_rdy=0.
REQ-022 SHALL accept back-to-back reads at 1 per cycle with rsp_rdy=1 held.
REQ-023 SHALL allow writes to proceed while responses are back-pressured, with in-order single-port semantics: a read issued before a write returns the old data.

Reset
REQ-024 SHALL reset asynchronously on cpurst_b=0: rsp_vld=0, rsp_rdata=0, FIFO empty, inflight=0, sweep counter=0, sram_a=0, sram_cen=1, sram_gwen=1, sram_wen=all-ones, sram_d=0.
REQ-025 SHALL reset init_done to 0 when CT_SPSRAM_INIT_EN is defined and to 1 otherwise.
REQ-026 A reset asserted mid-sweep or mid-read SHALL discard all in-flight state; the sweep restarts at address 0.

Configuration
REQ-027 With CT_SPSRAM_INIT_EN defined, INIT SHALL write zeros (cen=0, gwen=0, wen=0, d=0) to addresses 0..255, one per cycle, for 256 cycles, and init_done SHALL rise the cycle after the address-255 write.
REQ-028 Without CT_SPSRAM_INIT_EN, the sweep counter SHALL be absent, the FSM SHALL leave INIT on the first cycle after reset, and init_done SHALL be constant 1.

Structure
REQ-029 SHALL place ADDR_WIDTH/DATA_WIDTH defaults, DEPTH=256 and the state enum in package ct_spsram_ctrl_pkg.
REQ-030 SHALL implement the 2-entry response FIFO as sub-module ct_spsram_rsp_fifo.

Verification
REQ-031 SHALL test reset release with the macro: init_done=0 for 256 cycles, addresses 0..255 written with 0, then init_done=1 and req_rdy=1.
REQ-032 SHALL test write addr 0x12 data all-ones with mask 0x0..0FF, then a read of 0x12 -> rsp_rdata=0x0..0FF two cycles after acceptance.
REQ-033 SHALL test 4 back-to-back reads of addrs 1..4 with rsp_rdy=1 -> 4 responses on consecutive cycles, in order.
REQ-034 SHALL test rsp_rdy=0 while issuing reads -> req_rdy drops after 2 outstanding reads, rsp_rdata is stable, and nothing is lost after rsp_rdy=1.
REQ-035 SHALL test a write with a zero mask -> req_rdy=1, sram_cen stays 1, and the array is unchanged.
REQ-036 SHALL test cpurst_b pulsed at sweep address 100 -> the sweep restarts at 0 and init_done is delayed a full 256 cycles.
